traffic_phase_scheduler: RTL and testbench

- Two-approach traffic-light sequencer with a pedestrian-request service phase.
- Generates its own one-second tick from CLK100MHZ and steps a phase FSM: green, yellow, all-red for road 1, then the same for road 2.
- Exports light drives, a walk lamp, the current phase code and the seconds remaining, so a seven-segment display block can show the countdown.
- Replaces free-running seconds-counter decoding with an explicit scheduler.

---
 rtl/traffic_phase_scheduler_pkg.sv | 44 ++++
 rtl/traffic_phase_scheduler_sync_edge_detect.sv | 27 ++
 rtl/traffic_phase_scheduler.sv | 143 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and constants for the traffic phase scheduler.
// Phase codes, lamp encodings and countdown width.
package traffic_phase_scheduler_pkg;

  localparam int REM_W = 6;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    AR1 = 3'd0,
    G1  = 3'd1,
    Y1  = 3'd2,
    AR2 = 3'd3,
    G2  = 3'd4,
    Y2  = 3'd5,
    PW  = 3'd6,
    BAD = 3'd7
  } phase_e;

  typedef struct packed {
    logic [2:0] l1;
    logic [2:0] l2;
    logic       walk;
  } lamps_t;

  function automatic lamps_t lamp_decode(phase_e p);
    lamps_t l;
    l.l1   = RED;
    l.l2   = RED;
    l.walk = 1'b0;
    unique case (p)
      G1:      l.l1 = GRN;
      Y1:      l.l1 = YEL;
      G2:      l.l2 = GRN;
      Y2:      l.l2 = YEL;
      PW:      l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level input,
// followed by a one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain plus delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light sequencer with pedestrian walk phase.
// Own tick prescaler, phase FSM and registered lamp drives.
module traffic_phase_scheduler
  import traffic_phase_scheduler_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int T_GREEN     = 10,
  parameter int T_GREEN_MIN = 5,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 8
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             BTN_PED,
  input  logic             HOLD,
  output logic [2:0]       LIGHT1,
  output logic [2:0]       LIGHT2,
  output logic             WALK,
  output logic             PED_PEND,
  output logic [2:0]       PHASE,
  output logic [REM_W-1:0] REMAIN,
  output logic             TICK
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);
  localparam logic [REM_W-1:0] TRUNC_AT =
    REM_W'(T_GREEN - T_GREEN_MIN + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  phase_e           state_q, state_d;
  phase_e           nxt;
  logic [REM_W-1:0] remain_q, remain_d;
  logic             road_q, road_d;
  logic             ped_q, ped_d;
  lamps_t           lamp_q, lamp_d;
  logic             tick;
  logic             ped_rise;
  logic             go;

  function automatic logic [REM_W-1:0] dur(phase_e p);
    logic [REM_W-1:0] d;
    unique case (p)
      G1, G2:  d = REM_W'(T_GREEN);
      Y1, Y2:  d = REM_W'(T_YELLOW);
      PW:      d = REM_W'(T_WALK);
      default: d = REM_W'(T_ALLRED);
    endcase
    return d;
  endfunction

  sync_edge_detect u_sync (
    .clk_i  (CLK100MHZ),
    .rst_i  (RST),
    .d_i    (BTN_PED),
    .rise_o (ped_rise)
  );

  // Prescaler: wraps at CLK_HZ-1, frozen while HOLD
  always_comb begin
    tick  = (cnt_q == CNT_MAX) && !HOLD;
    cnt_d = cnt_q;
    if (!HOLD) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Phase selection, countdown and pedestrian latch
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    road_d   = road_q;
    ped_d    = ped_q;
    nxt      = AR1;
    go       = 1'b0;

    unique case (state_q)
      AR1:     nxt = G1;
      G1:      nxt = Y1;
      Y1:      nxt = ped_q ? PW : AR2;
      AR2:     nxt = G2;
      G2:      nxt = Y2;
      Y2:      nxt = ped_q ? PW : AR1;
      PW:      nxt = road_q ? AR2 : AR1;
      default: nxt = AR1;
    endcase

    if (state_q == BAD) begin
      state_d  = AR1;
      remain_d = REM_W'(T_ALLRED);
    end else if (tick) begin
      go = (remain_q == REM_W'(1)) ||
           (((state_q == G1) || (state_q == G2)) &&
            ped_q && (remain_q <= TRUNC_AT));
      if (go) begin
        state_d  = nxt;
        remain_d = dur(nxt);
        if (nxt == PW) begin
          road_d = (state_q == Y1);
        end
      end else begin
        remain_d = remain_q - 1'b1;
      end
    end

    if ((state_d == PW) && (state_q != PW)) begin
      ped_d = 1'b0;
    end else if (ped_rise && (state_q != PW)) begin
      ped_d = 1'b1;
    end

    lamp_d = lamp_decode(state_d);
  end

  // State registers; reset wins over HOLD
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      cnt_q    <= '0;
      state_q  <= AR1;
      remain_q <= REM_W'(T_ALLRED);
      road_q   <= 1'b0;
      ped_q    <= 1'b0;
      lamp_q   <= '{l1: RED, l2: RED, walk: 1'b0};
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      remain_q <= remain_d;
      road_q   <= road_d;
      ped_q    <= ped_d;
      lamp_q   <= lamp_d;
    end
  end

  assign LIGHT1   = lamp_q.l1;
  assign LIGHT2   = lamp_q.l2;
  assign WALK     = lamp_q.walk;
  assign PED_PEND = ped_q;
  assign PHASE    = state_q;
  assign REMAIN   = remain_q;
  assign TICK     = tick;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with CLK_HZ=4.
// Expected values are hand-computed edge counts from reset release.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       hold;
  logic [2:0] l1, l2;
  logic       walk, pend, tick;
  logic [2:0] phase;
  logic [5:0] remain;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .CLK_HZ      (4),
    .T_GREEN     (10),
    .T_GREEN_MIN (5),
    .T_YELLOW    (3),
    .T_ALLRED    (2),
    .T_WALK      (8)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .BTN_PED   (btn),
    .HOLD      (hold),
    .LIGHT1    (l1),
    .LIGHT2    (l2),
    .WALK      (walk),
    .PED_PEND  (pend),
    .PHASE     (phase),
    .REMAIN    (remain),
    .TICK      (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert (!((l1 !== 3'b100) && (l2 !== 3'b100))) else begin
        errors++;
        $error("FAIL conflict observed=%b_%b expected=one_red", l1, l2);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    btn  = 1'b0;
    hold = 1'b0;
    adv(2);
    chk("rst_phase", phase, 0);
    chk("rst_remain", remain, 2);
    chk("rst_l1", l1, 3'b100);
    chk("rst_l2", l2, 3'b100);
    chk("rst_walk", walk, 0);
    chk("rst_pend", pend, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b0;

    // plain cycle
    adv(3);
    chk("t1_ar1", phase, 0);
    chk("t1_rem2", remain, 2);
    chk("t1_tick", tick, 1);
    adv(1);
    chk("t1_rem1", remain, 1);
    chk("t1_tick0", tick, 0);
    adv(3);
    chk("t1_ar1_end", phase, 0);
    adv(1);
    chk("t1_g1", phase, 1);
    chk("t1_g1_l1", l1, 3'b001);
    chk("t1_g1_l2", l2, 3'b100);
    for (int k = 0; k < 10; k++) begin
      chk("t1_g1_rem", remain, 10 - k);
      adv(4);
    end
    chk("t1_y1", phase, 2);
    chk("t1_y1_rem", remain, 3);
    chk("t1_y1_l1", l1, 3'b010);
    adv(12);
    chk("t1_ar2", phase, 3);
    chk("t1_ar2_rem", remain, 2);
    chk("t1_ar2_l1", l1, 3'b100);
    adv(8);
    chk("t1_g2", phase, 4);
    chk("t1_g2_l2", l2, 3'b001);
    chk("t1_g2_rem", remain, 10);
    adv(40);
    chk("t1_y2", phase, 5);
    chk("t1_y2_l2", l2, 3'b010);
    adv(12);
    chk("t1_back_ar1", phase, 0);
    chk("t1_back_rem", remain, 2);

    // press 3 clocks into G1, green truncated
    adv(11);
    chk("t2_g1", phase, 1);
    btn = 1'b1;
    adv(2);
    chk("t2_pend_early", pend, 0);
    adv(1);
    chk("t2_pend", pend, 1);
    btn = 1'b0;
    adv(13);
    chk("t2_g1_last", phase, 1);
    chk("t2_g1_rem6", remain, 6);
    adv(1);
    chk("t2_y1", phase, 2);
    chk("t2_y1_rem", remain, 3);
    adv(12);
    chk("t2_pw", phase, 6);
    chk("t2_pw_walk", walk, 1);
    chk("t2_pw_pend", pend, 0);
    chk("t2_pw_rem", remain, 8);
    chk("t2_pw_l1", l1, 3'b100);
    adv(31);
    chk("t2_pw_last", phase, 6);
    adv(1);
    chk("t2_ar2", phase, 3);
    chk("t2_ar2_walk", walk, 0);
    chk("t2_ar2_rem", remain, 2);

    // press at G2 REMAIN=2, no truncation
    adv(41);
    chk("t3_g2", phase, 4);
    chk("t3_g2_rem2", remain, 2);
    btn = 1'b1;
    adv(3);
    chk("t3_pend", pend, 1);
    chk("t3_rem1", remain, 1);
    chk("t3_still_g2", phase, 4);
    adv(3);
    chk("t3_g2_end", phase, 4);
    adv(1);
    chk("t3_y2", phase, 5);
    chk("t3_y2_rem", remain, 3);
    btn = 1'b0;
    adv(12);
    chk("t3_pw", phase, 6);
    chk("t3_pw_pend", pend, 0);
    chk("t3_pw_walk", walk, 1);
    adv(32);
    chk("t3_ar1", phase, 0);
    chk("t3_ar1_walk", walk, 0);

    // double press, then press during PW
    adv(8);
    chk("t4_g1", phase, 1);
    btn = 1'b1;
    adv(3);
    chk("t4_pend", pend, 1);
    adv(1);
    btn = 1'b0;
    adv(4);
    btn = 1'b1;
    adv(4);
    btn = 1'b0;
    adv(1);
    chk("t4_pend_hold", pend, 1);
    adv(7);
    chk("t4_y1", phase, 2);
    adv(12);
    chk("t4_pw", phase, 6);
    chk("t4_pw_pend", pend, 0);
    adv(6);
    btn = 1'b1;
    adv(4);
    btn = 1'b0;
    adv(2);
    chk("t4_pw_press_ign", pend, 0);
    adv(20);
    chk("t4_ar2", phase, 3);
    chk("t4_ar2_pend", pend, 0);
    adv(48);
    chk("t4_y2", phase, 5);
    adv(12);
    chk("t4_ar1_no_pw", phase, 0);
    chk("t4_end_pend", pend, 0);

    // HOLD freeze mid-G1
    adv(20);
    chk("t5_g1", phase, 1);
    chk("t5_rem7", remain, 7);
    adv(1);
    hold = 1'b1;
    adv(50);
    chk("t5_hold_rem", remain, 7);
    chk("t5_hold_l1", l1, 3'b001);
    chk("t5_hold_phase", phase, 1);
    chk("t5_hold_tick", tick, 0);
    adv(50);
    chk("t5_hold_rem_end", remain, 7);
    hold = 1'b0;
    adv(1);
    chk("t5_tick_no", tick, 0);
    adv(1);
    chk("t5_tick_yes", tick, 1);
    chk("t5_rem_pre", remain, 7);
    adv(1);
    chk("t5_rem6", remain, 6);
    chk("t5_tick_off", tick, 0);

    // reset mid-Y2 under HOLD
    adv(84);
    chk("t6_y2", phase, 5);
    btn = 1'b1;
    adv(3);
    chk("t6_pend", pend, 1);
    btn = 1'b0;
    adv(2);
    chk("t6_y2_mid", phase, 5);
    hold = 1'b1;
    rst  = 1'b1;
    adv(1);
    chk("t6_phase", phase, 0);
    chk("t6_rem", remain, 2);
    chk("t6_l1", l1, 3'b100);
    chk("t6_l2", l2, 3'b100);
    chk("t6_pend0", pend, 0);
    chk("t6_tick", tick, 0);
    chk("t6_walk", walk, 0);
    rst  = 1'b0;
    hold = 1'b0;
    adv(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
